// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared constants and response tag type for the debug-module bus arbiter
package dm_arb_pkg;

    localparam int   NR_HOSTS      = 2;
    localparam logic HOST_DEV      = 1'b0;
    localparam logic HOST_DBG      = 1'b1;
    localparam int   MAX_SLAVE_LAT = 3;

    typedef struct packed {
        logic valid;
        logic host_id;
        logic we;
    } resp_tag_t;

endpackage

// File: rtl/dm_arb_resp_pipe.sv
// dm_arb_resp_pipe: tag shift register matching the slave read latency, with synchronous flush
module dm_arb_resp_pipe
    import dm_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      clear_i,
    input  resp_tag_t tag_i,
    output resp_tag_t tag_o
);

    resp_tag_t stage [DEPTH];

    // shift one stage per cycle; flush drops every in-flight tag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_o = stage[DEPTH-1];

endmodule

// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter: shares the debug-module slave between the device bus and debug fetch.
// Define DM_ARB_ROUND_ROBIN_EN to alternate priority on simultaneous requests.
module dm_bus_arbiter
    import dm_arb_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int SLAVE_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              h0_req_i,
    input  logic              h0_we_i,
    input  logic [XLEN/8-1:0] h0_be_i,
    input  logic [XLEN-1:0]   h0_addr_i,
    input  logic [XLEN-1:0]   h0_wdata_i,
    output logic              h0_gnt_o,
    output logic              h0_rvalid_o,
    output logic [XLEN-1:0]   h0_rdata_o,
    input  logic              h1_req_i,
    input  logic [XLEN-1:0]   h1_addr_i,
    output logic              h1_gnt_o,
    output logic              h1_rvalid_o,
    output logic [XLEN-1:0]   h1_rdata_o,
    output logic              slv_req_o,
    output logic              slv_we_o,
    output logic [XLEN/8-1:0] slv_be_o,
    output logic [XLEN-1:0]   slv_addr_o,
    output logic [XLEN-1:0]   slv_wdata_o,
    input  logic [XLEN-1:0]   slv_rdata_i
);

    logic      sel_dbg;
    logic      en;
    resp_tag_t tag_in;
    resp_tag_t tag_out;
    logic      unused_we;

`ifdef DM_ARB_ROUND_ROBIN_EN
    logic last;

    // remember who was granted most recently; starts as if host1 went last
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last <= HOST_DBG;
        else if (slv_req_o) last <= h1_gnt_o;
    end

    assign sel_dbg = h1_req_i & (~h0_req_i | (last == HOST_DEV));
`else
    assign sel_dbg = h1_req_i & ~h0_req_i;
`endif

    // grants are blocked in reset and in a flush cycle so nothing enters a dying pipe
    assign en       = rst_ni & ~clear_i;
    assign h0_gnt_o = en & h0_req_i & ~sel_dbg;
    assign h1_gnt_o = en & sel_dbg;
    assign slv_req_o = h0_gnt_o | h1_gnt_o;

    // route the granted host's fields; fetches are full-word reads
    always_comb begin
        slv_we_o    = h0_gnt_o & h0_we_i;
        slv_be_o    = h0_gnt_o ? h0_be_i : (h1_gnt_o ? '1 : '0);
        slv_addr_o  = h0_gnt_o ? h0_addr_i : (h1_gnt_o ? h1_addr_i : '0);
        slv_wdata_o = h0_gnt_o ? h0_wdata_i : '0;
    end

    assign tag_in = '{valid: slv_req_o, host_id: h1_gnt_o, we: slv_we_o};

    dm_arb_resp_pipe #(.DEPTH(SLAVE_LAT)) u_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear_i(clear_i),
        .tag_i  (tag_in),
        .tag_o  (tag_out)
    );

    assign unused_we = tag_out.we;

    assign h0_rvalid_o = tag_out.valid & (tag_out.host_id == HOST_DEV);
    assign h1_rvalid_o = tag_out.valid & (tag_out.host_id == HOST_DBG);
    assign h0_rdata_o  = h0_rvalid_o ? slv_rdata_i : '0;
    assign h1_rdata_o  = h1_rvalid_o ? slv_rdata_i : '0;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// tb_dm_bus_arbiter: directed scoreboard bench over SLAVE_LAT = 1, 2, 3 instances sharing stimulus
module tb_dm_bus_arbiter;

    localparam logic [31:0] KEY = 32'hDF345668;

    typedef struct {
        int          inst;
        int          due;
        logic        host;
        logic [31:0] data;
    } exp_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        clear = 0;
    logic        h0_req = 0, h0_we = 0, h1_req = 0;
    logic [3:0]  h0_be = 0;
    logic [31:0] h0_addr = 0, h0_wdata = 0, h1_addr = 0;

    logic        h0_gnt [3], h0_rv [3], h1_gnt [3], h1_rv [3], s_req [3], s_we [3];
    logic [3:0]  s_be [3];
    logic [31:0] h0_rd [3], h1_rd [3], s_addr [3], s_wdata [3], s_rdata [3];

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int L = g + 1;
        logic [31:0] sa [L];
        logic        sv [L];

        dm_bus_arbiter #(.XLEN(32), .SLAVE_LAT(L)) dut (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .clear_i    (clear),
            .h0_req_i   (h0_req),
            .h0_we_i    (h0_we),
            .h0_be_i    (h0_be),
            .h0_addr_i  (h0_addr),
            .h0_wdata_i (h0_wdata),
            .h0_gnt_o   (h0_gnt[g]),
            .h0_rvalid_o(h0_rv[g]),
            .h0_rdata_o (h0_rd[g]),
            .h1_req_i   (h1_req),
            .h1_addr_i  (h1_addr),
            .h1_gnt_o   (h1_gnt[g]),
            .h1_rvalid_o(h1_rv[g]),
            .h1_rdata_o (h1_rd[g]),
            .slv_req_o  (s_req[g]),
            .slv_we_o   (s_we[g]),
            .slv_be_o   (s_be[g]),
            .slv_addr_o (s_addr[g]),
            .slv_wdata_o(s_wdata[g]),
            .slv_rdata_i(s_rdata[g])
        );

        // slave model: answers addr ^ KEY exactly L cycles after each request, junk otherwise
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < L; k++) begin
                    sa[k] <= '0;
                    sv[k] <= 1'b0;
                end
            end else begin
                sa[0] <= s_addr[g];
                sv[0] <= s_req[g];
                for (int k = 1; k < L; k++) begin
                    sa[k] <= sa[k-1];
                    sv[k] <= sv[k-1];
                end
            end
        end

        assign s_rdata[g] = sv[L-1] ? (sa[L-1] ^ KEY) : 32'hBAD0BAD0;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, got, exp);
        else passed++;
    endtask

    task automatic chk_gnt(input logic g0, input logic g1, input string nm);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_h0gnt_i%0d", nm, i), 32'(h0_gnt[i]), 32'(g0));
            chk($sformatf("%s_h1gnt_i%0d", nm, i), 32'(h1_gnt[i]), 32'(g1));
            chk($sformatf("%s_slvreq_i%0d", nm, i), 32'(s_req[i]), 32'(g0 | g1));
        end
    endtask

    task automatic push_one(input int i, input logic h, input logic [31:0] d);
        exp_t e;
        e.inst = i;
        e.due  = cyc + i + 1;
        e.host = h;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic push_exp(input logic h, input logic [31:0] d);
        for (int i = 0; i < 3; i++) push_one(i, h, d);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        h0_req = 0; h0_we = 0; h0_be = 0; h0_addr = 0; h0_wdata = 0;
        h1_req = 0; h1_addr = 0; clear = 0;
    endtask

    // monitor: every cycle each host of each instance must show rvalid exactly when due
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int h = 0; h < 2; h++) begin
                int          idx;
                logic        rv, hit;
                logic [31:0] rd;
                idx = -1;
                for (int k = 0; k < sb.size(); k++)
                    if (idx < 0 && sb[k].inst == i && sb[k].host == h[0]) idx = k;
                rv  = h[0] ? h1_rv[i] : h0_rv[i];
                rd  = h[0] ? h1_rd[i] : h0_rd[i];
                hit = (idx >= 0) && (sb[idx].due == cyc);
                chk($sformatf("rvalid_h%0d_i%0d", h, i), 32'(rv), 32'(hit));
                if (rv && idx >= 0) begin
                    chk($sformatf("rdata_h%0d_i%0d", h, i), rd, sb[idx].data);
                    sb.delete(idx);
                end else if (!rv) begin
                    chk($sformatf("rdata_idle_h%0d_i%0d", h, i), rd, 32'h0);
                    if (hit) sb.delete(idx);
                end
            end
        end
    end

    initial begin
        logic        rr;
        logic [31:0] n0, n1;
`ifdef DM_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        // reset holds every output at zero even with both requests raised
        idle();
        h0_req = 1; h1_req = 1; h0_addr = 32'hCD000010; h1_addr = 32'hCD000800;
        @(negedge clk);
        chk_gnt(0, 0, "in_reset");
        chk("in_reset_addr", s_addr[0], 32'h0);
        next_cycle();
        idle();
        next_cycle();
        rst_n = 1;
        next_cycle();

        // single host0 read
        h0_req = 1; h0_addr = 32'hCD000010;
        @(negedge clk);
        chk_gnt(1, 0, "rd0");
        chk("rd0_addr", s_addr[0], 32'hCD000010);
        chk("rd0_we", 32'(s_we[0]), 32'h0);
        push_exp(0, 32'h12345678);
        next_cycle();
        idle();

        // host0 write with partial byte enables
        h0_req = 1; h0_we = 1; h0_be = 4'b0011; h0_addr = 32'hCD000020; h0_wdata = 32'hAABBCCDD;
        @(negedge clk);
        chk_gnt(1, 0, "wr0");
        chk("wr0_we", 32'(s_we[0]), 32'h1);
        chk("wr0_be", 32'(s_be[0]), 32'h3);
        chk("wr0_wdata", s_wdata[0], 32'hAABBCCDD);
        push_exp(0, 32'h12345648);
        next_cycle();
        idle();
        repeat (4) next_cycle();

        // simultaneous requests; after the host0 write the round-robin pointer prefers host1
        h0_req = 1; h0_addr = 32'hCD000030; h1_req = 1; h1_addr = 32'hCD000800;
        @(negedge clk);
        if (rr) begin
            chk_gnt(0, 1, "both_a");
            chk("both_a_be", 32'(s_be[0]), 32'hF);
            push_exp(1, 32'h12345E68);
            next_cycle();
            h1_req = 0;
            @(negedge clk);
            chk_gnt(1, 0, "both_b");
            push_exp(0, 32'h12345658);
        end else begin
            chk_gnt(1, 0, "both_a");
            push_exp(0, 32'h12345658);
            next_cycle();
            h0_req = 0;
            @(negedge clk);
            chk_gnt(0, 1, "both_b");
            chk("both_b_be", 32'(s_be[0]), 32'hF);
            chk("both_b_we", 32'(s_we[0]), 32'h0);
            push_exp(1, 32'h12345E68);
        end
        next_cycle();
        idle();
        repeat (4) next_cycle();

        // three back-to-back fetches
        h1_req = 1; h1_addr = 32'hCD000800;
        @(negedge clk); chk_gnt(0, 1, "f0"); push_exp(1, 32'h12345E68);
        next_cycle(); h1_addr = 32'hCD000804;
        @(negedge clk); chk_gnt(0, 1, "f1"); push_exp(1, 32'h12345E6C);
        next_cycle(); h1_addr = 32'hCD000808;
        @(negedge clk); chk_gnt(0, 1, "f2"); push_exp(1, 32'h12345E60);
        next_cycle();
        idle();
        repeat (5) next_cycle();

        // clear one cycle after a fetch: latency-1 response retires before the flush, deeper ones die
        h1_req = 1; h1_addr = 32'hCD00080C;
        @(negedge clk);
        chk_gnt(0, 1, "pre_clr");
        push_one(0, 1, 32'h12345E64);
        next_cycle();
        idle();
        clear = 1; h0_req = 1; h0_addr = 32'hCD000040;
        @(negedge clk);
        chk_gnt(0, 0, "in_clr");
        next_cycle();
        clear = 0;
        @(negedge clk);
        chk_gnt(1, 0, "post_clr");
        push_exp(0, 32'h12345628);
        next_cycle();
        idle();
        repeat (5) next_cycle();

        // reset mid-transaction: outputs drop immediately and the grant never answers
        h0_req = 1; h0_addr = 32'hCD000050;
        @(negedge clk);
        chk_gnt(1, 0, "pre_rst");
        #1 rst_n = 0;
        #1;
        chk_gnt(0, 0, "mid_rst");
        chk("mid_rst_addr", s_addr[0], 32'h0);
        next_cycle();
        next_cycle();
        rst_n = 1;

        // continuous double requests after reset
        n0 = 32'hCD000060; n1 = 32'hCD000900;
        for (int k = 0; k < 4; k++) begin
            logic w0;
            h0_req = 1; h0_addr = n0; h1_req = 1; h1_addr = n1;
            w0 = rr ? (k % 2 == 0) : 1'b1;
            @(negedge clk);
            chk_gnt(w0, !w0, $sformatf("dbl%0d", k));
            push_exp(!w0, (w0 ? n0 : n1) ^ KEY);
            if (w0) n0 = n0 + 4; else n1 = n1 + 4;
            next_cycle();
        end
        h0_req = 0; h1_addr = n1;
        @(negedge clk);
        chk_gnt(0, 1, "dbl_tail");
        push_exp(1, n1 ^ KEY);
        next_cycle();
        idle();
        repeat (6) next_cycle();

        @(negedge clk);
        chk("drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
